// File: rtl/id_stall_controller.sv
// id_stall_controller
//  ID-stage stall/flush control for the 5-stage MIPS pipeline. Detects
//  load-use and branch-operand hazards that EX/MEM->ID forwarding cannot
//  cover, holds PC and IF/ID for one or two cycles, bubbles ID/EX while
//  stalled and flushes IF/ID on a taken branch.
// Ports
//  i_clk, i_rst            clock, synchronous active-high reset
//  i_rs_id, i_rt_id        source registers of the instruction in ID
//  i_uses_rt_id            ID instruction reads rt
//  i_branch_id             ID instruction compares operands in ID
//  i_branch_taken_id       branch in ID resolved taken
//  i_rd_id_ex, i_regWrite_id_ex, i_memRead_id_ex   producer in EX
//  i_rd_ex_m, i_memRead_ex_m                       producer in MEM
//  i_halt                  debug freeze, overrides stall/flush outputs
//  o_stall_pc, o_stall_if_id, o_bubble_id_ex       stall controls
//  o_flush_if_id           load NOP into IF/ID
//  o_stall_count           saturating count of stall cycles since reset
module id_stall_controller #(
    parameter int unsigned NB_ADDR = 5,
    parameter int unsigned NB_CNT  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_ADDR-1:0] i_rs_id,
    input  logic [NB_ADDR-1:0] i_rt_id,
    input  logic               i_uses_rt_id,
    input  logic               i_branch_id,
    input  logic               i_branch_taken_id,
    input  logic [NB_ADDR-1:0] i_rd_id_ex,
    input  logic               i_regWrite_id_ex,
    input  logic               i_memRead_id_ex,
    input  logic [NB_ADDR-1:0] i_rd_ex_m,
    input  logic               i_memRead_ex_m,
    input  logic               i_halt,
    output logic               o_stall_pc,
    output logic               o_stall_if_id,
    output logic               o_bubble_id_ex,
    output logic               o_flush_if_id,
    output logic [NB_CNT-1:0]  o_stall_count
);

    localparam logic [NB_CNT-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STALL2 = 1'b1
    } state_t;

    state_t            state_q;
    logic [NB_CNT-1:0] cnt_q;

    logic match_a;
    logic match_b;
    logic need_two;
    logic need_one;
    logic stall;
    logic flush;

    // Operand matches against EX and MEM producers; $0 never creates a hazard.
    always_comb begin
        match_a = (i_rd_id_ex != '0) &&
                  ((i_rs_id == i_rd_id_ex) || (i_uses_rt_id && (i_rt_id == i_rd_id_ex)));
        match_b = (i_rd_ex_m != '0) &&
                  ((i_rs_id == i_rd_ex_m) || (i_uses_rt_id && (i_rt_id == i_rd_ex_m)));
    end

    // Stall length requirement; overlapping rules take the maximum, not the sum.
    always_comb begin
        need_two = i_memRead_id_ex && match_a && i_branch_id;
        need_one = (i_memRead_id_ex && match_a && !i_branch_id) ||
                   (i_regWrite_id_ex && !i_memRead_id_ex && match_a && i_branch_id) ||
                   (i_memRead_ex_m && match_b && i_branch_id);
    end

    // Output decode: halt and reset force everything low; a stall masks the flush.
    always_comb begin
        stall = 1'b0;
        flush = 1'b0;
        if (!i_rst && !i_halt) begin
            stall = (state_q == STALL2) || need_two || need_one;
            flush = i_branch_taken_id && !stall;
        end
    end

    assign o_stall_pc     = stall;
    assign o_stall_if_id  = stall;
    assign o_bubble_id_ex = stall;
    assign o_flush_if_id  = flush;
    assign o_stall_count  = i_rst ? '0 : cnt_q;

    // State and saturating stall counter; halt freezes both.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (!i_halt) begin
            if ((state_q == IDLE) && need_two) begin
                state_q <= STALL2;
            end else begin
                state_q <= IDLE;
            end
            if (stall && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + NB_CNT'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_stall_controller.sv
// Directed bench for id_stall_controller: load-use, branch hazards,
// register-0 exclusion, reset during STALL2, halt and counter saturation.
module tb_id_stall_controller;

    logic       clk;
    logic       rst;
    logic [4:0] rs_id, rt_id, rd_id_ex, rd_ex_m;
    logic       uses_rt_id, branch_id, branch_taken_id;
    logic       regwrite_id_ex, memread_id_ex, memread_ex_m, halt;

    logic        stall_pc, stall_if_id, bubble_id_ex, flush_if_id;
    logic [15:0] stall_count;
    logic        s_stall_pc, s_stall_if_id, s_bubble_id_ex, s_flush_if_id;
    logic [3:0]  s_stall_count;

    int checks = 0;
    int errors = 0;

    id_stall_controller #(.NB_ADDR(5), .NB_CNT(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rs_id(rs_id), .i_rt_id(rt_id), .i_uses_rt_id(uses_rt_id),
        .i_branch_id(branch_id), .i_branch_taken_id(branch_taken_id),
        .i_rd_id_ex(rd_id_ex), .i_regWrite_id_ex(regwrite_id_ex),
        .i_memRead_id_ex(memread_id_ex),
        .i_rd_ex_m(rd_ex_m), .i_memRead_ex_m(memread_ex_m),
        .i_halt(halt),
        .o_stall_pc(stall_pc), .o_stall_if_id(stall_if_id),
        .o_bubble_id_ex(bubble_id_ex), .o_flush_if_id(flush_if_id),
        .o_stall_count(stall_count)
    );

    id_stall_controller #(.NB_ADDR(5), .NB_CNT(4)) dut_small (
        .i_clk(clk), .i_rst(rst),
        .i_rs_id(rs_id), .i_rt_id(rt_id), .i_uses_rt_id(uses_rt_id),
        .i_branch_id(branch_id), .i_branch_taken_id(branch_taken_id),
        .i_rd_id_ex(rd_id_ex), .i_regWrite_id_ex(regwrite_id_ex),
        .i_memRead_id_ex(memread_id_ex),
        .i_rd_ex_m(rd_ex_m), .i_memRead_ex_m(memread_ex_m),
        .i_halt(halt),
        .o_stall_pc(s_stall_pc), .o_stall_if_id(s_stall_if_id),
        .o_bubble_id_ex(s_bubble_id_ex), .o_flush_if_id(s_flush_if_id),
        .o_stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic br, input logic tk);
        rs_id = rs; rt_id = rt; uses_rt_id = urt; branch_id = br; branch_taken_id = tk;
    endtask

    task automatic set_ex(input logic [4:0] rd, input logic rw, input logic mr);
        rd_id_ex = rd; regwrite_id_ex = rw; memread_id_ex = mr;
    endtask

    task automatic set_m(input logic [4:0] rd, input logic mr);
        rd_ex_m = rd; memread_ex_m = mr;
    endtask

    task automatic quiet();
        set_id(5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        set_ex(5'd0, 1'b0, 1'b0);
        set_m(5'd0, 1'b0);
        halt = 1'b0;
    endtask

    // Advance to the next negedge and let combinational outputs settle.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        quiet();
        set_ex(5'd1, 1'b1, 1'b1);   // hazard present, but reset forces outputs low
        repeat (2) @(negedge clk);
        settle();
        checks++;
        if ({stall_pc, stall_if_id, bubble_id_ex, flush_if_id} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000",
                     {stall_pc, stall_if_id, bubble_id_ex, flush_if_id});
        end
        checks++;
        if (stall_count !== 16'd0) begin
            errors++; $display("FAIL reset_count got=%0d exp=0", stall_count);
        end
        quiet();
        step(); rst = 1'b0;
        step(); settle();
        checks++;
        if (stall_pc !== 1'b0 || stall_count !== 16'd0) begin
            errors++; $display("FAIL reset_idle stall=%b cnt=%0d exp 0/0", stall_pc, stall_count);
        end
    endtask

    task automatic test_load_use();
        logic [15:0] c0;
        c0 = stall_count;
        set_ex(5'd3, 1'b1, 1'b1);
        set_id(5'd3, 5'd7, 1'b1, 1'b0, 1'b0);
        settle();
        checks++;
        if ({stall_pc, stall_if_id, bubble_id_ex} !== 3'b111) begin
            errors++; $display("FAIL loaduse_stall got=%b exp=111", {stall_pc, stall_if_id, bubble_id_ex});
        end
        checks++;
        if (c0 !== 16'd0) begin
            errors++; $display("FAIL loaduse_count_start got=%0d exp=0", c0);
        end
        step();
        set_ex(5'd0, 1'b0, 1'b0);
        set_m(5'd3, 1'b1);
        settle();
        checks++;
        if (stall_pc !== 1'b0 || stall_count !== 16'd1) begin
            errors++; $display("FAIL loaduse_release stall=%b cnt=%0d exp 0/1", stall_pc, stall_count);
        end
    endtask

    task automatic test_branch_load();
        logic [15:0] c0;
        step(); quiet(); settle();
        c0 = stall_count;
        set_ex(5'd4, 1'b1, 1'b1);
        set_id(5'd4, 5'd9, 1'b1, 1'b1, 1'b1);
        settle();
        checks++;
        if (stall_pc !== 1'b1 || flush_if_id !== 1'b0) begin
            errors++; $display("FAIL brload_c1 stall=%b flush=%b exp 1/0", stall_pc, flush_if_id);
        end
        step();
        set_ex(5'd0, 1'b0, 1'b0);
        set_m(5'd0, 1'b0);   // inputs show no hazard: STALL2 must stall on its own
        settle();
        checks++;
        if (stall_pc !== 1'b1 || flush_if_id !== 1'b0) begin
            errors++; $display("FAIL brload_c2 stall=%b flush=%b exp 1/0", stall_pc, flush_if_id);
        end
        step(); settle();
        checks++;
        if (stall_pc !== 1'b0 || flush_if_id !== 1'b1) begin
            errors++; $display("FAIL brload_flush stall=%b flush=%b exp 0/1", stall_pc, flush_if_id);
        end
        checks++;
        if (stall_count !== c0 + 16'd2) begin
            errors++; $display("FAIL brload_count got=%0d exp=%0d", stall_count, c0 + 16'd2);
        end
        step(); quiet(); settle();
        checks++;
        if (flush_if_id !== 1'b0) begin
            errors++; $display("FAIL brload_flush_once got=%b exp=0", flush_if_id);
        end
    endtask

    task automatic test_branch_alu();
        step(); quiet();
        set_ex(5'd5, 1'b1, 1'b0);
        set_id(5'd1, 5'd5, 1'b1, 1'b1, 1'b0);
        settle();
        checks++;
        if (stall_pc !== 1'b1) begin
            errors++; $display("FAIL bralu_rt_used got=%b exp=1", stall_pc);
        end
        step(); settle();
        checks++;
        if (stall_pc !== 1'b1) begin
            errors++; $display("FAIL bralu_still_hazard got=%b exp=1", stall_pc);
        end
        uses_rt_id = 1'b0; settle();
        checks++;
        if (stall_pc !== 1'b0) begin
            errors++; $display("FAIL bralu_rt_unused got=%b exp=0", stall_pc);
        end
        step(); settle();
        checks++;
        if (stall_pc !== 1'b0) begin
            errors++; $display("FAIL bralu_one_cycle got=%b exp=0", stall_pc);
        end
        // Load in MEM feeding a branch: one cycle
        quiet();
        set_m(5'd6, 1'b1);
        set_id(5'd6, 5'd0, 1'b0, 1'b1, 1'b0);
        settle();
        checks++;
        if (stall_pc !== 1'b1) begin
            errors++; $display("FAIL brmem_stall got=%b exp=1", stall_pc);
        end
        step(); set_m(5'd0, 1'b0); settle();
        checks++;
        if (stall_pc !== 1'b0) begin
            errors++; $display("FAIL brmem_release got=%b exp=0", stall_pc);
        end
    endtask

    task automatic test_reg_zero();
        logic [15:0] c0;
        step(); quiet(); settle();
        c0 = stall_count;
        set_ex(5'd0, 1'b1, 1'b1);
        set_m(5'd0, 1'b1);
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        settle();
        checks++;
        if (stall_pc !== 1'b0) begin
            errors++; $display("FAIL regzero_stall got=%b exp=0", stall_pc);
        end
        step(); settle();
        checks++;
        if (stall_count !== c0) begin
            errors++; $display("FAIL regzero_count got=%0d exp=%0d", stall_count, c0);
        end
    endtask

    task automatic test_max_not_sum();
        logic [15:0] c0;
        step(); quiet(); settle();
        c0 = stall_count;
        set_ex(5'd8, 1'b1, 1'b1);
        set_m(5'd9, 1'b1);
        set_id(5'd8, 5'd9, 1'b1, 1'b1, 1'b0);
        settle();
        step(); quiet(); set_id(5'd8, 5'd9, 1'b1, 1'b1, 1'b0); settle();
        checks++;
        if (stall_pc !== 1'b1) begin
            errors++; $display("FAIL maxn_c2 got=%b exp=1", stall_pc);
        end
        step(); settle();
        checks++;
        if (stall_pc !== 1'b0 || stall_count !== c0 + 16'd2) begin
            errors++; $display("FAIL maxn_end stall=%b cnt=%0d exp 0/%0d",
                               stall_pc, stall_count, c0 + 16'd2);
        end
    endtask

    task automatic test_reset_in_stall2();
        step(); quiet();
        set_ex(5'd10, 1'b1, 1'b1);
        set_id(5'd10, 5'd0, 1'b0, 1'b1, 1'b0);
        step(); quiet();                 // now in STALL2
        rst = 1'b1; settle();
        checks++;
        if (stall_pc !== 1'b0 || stall_count !== 16'd0) begin
            errors++; $display("FAIL rststall2_during stall=%b cnt=%0d exp 0/0", stall_pc, stall_count);
        end
        step(); rst = 1'b0; settle();
        checks++;
        if ({stall_pc, stall_if_id, bubble_id_ex, flush_if_id} !== 4'b0000 ||
            stall_count !== 16'd0) begin
            errors++; $display("FAIL rststall2_after out=%b cnt=%0d exp 0000/0",
                               {stall_pc, stall_if_id, bubble_id_ex, flush_if_id}, stall_count);
        end
    endtask

    task automatic test_halt();
        logic [15:0] c0;
        step(); quiet(); settle();
        c0 = stall_count;
        halt = 1'b1;
        set_ex(5'd11, 1'b1, 1'b1);
        set_id(5'd11, 5'd0, 1'b0, 1'b1, 1'b1);
        settle();
        checks++;
        if ({stall_pc, flush_if_id} !== 2'b00) begin
            errors++; $display("FAIL halt_outputs got=%b exp=00", {stall_pc, flush_if_id});
        end
        step(); quiet(); settle();
        checks++;
        if (stall_pc !== 1'b0 || stall_count !== c0) begin
            errors++; $display("FAIL halt_freeze stall=%b cnt=%0d exp 0/%0d", stall_pc, stall_count, c0);
        end
        // Halt while in STALL2 keeps the pending stall cycle
        set_ex(5'd11, 1'b1, 1'b1);
        set_id(5'd11, 5'd0, 1'b0, 1'b1, 1'b0);
        step(); quiet(); halt = 1'b1;
        step(); step(); halt = 1'b0; settle();
        checks++;
        if (stall_pc !== 1'b1 || stall_count !== c0 + 16'd1) begin
            errors++; $display("FAIL halt_stall2_hold stall=%b cnt=%0d exp 1/%0d",
                               stall_pc, stall_count, c0 + 16'd1);
        end
        step(); settle();
        checks++;
        if (stall_pc !== 1'b0) begin
            errors++; $display("FAIL halt_stall2_done got=%b exp=0", stall_pc);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_cnt;
        step(); quiet(); rst = 1'b1;
        step(); rst = 1'b0;
        set_ex(5'd12, 1'b1, 1'b1);
        set_id(5'd12, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step(); settle();
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            checks++;
            if (s_stall_count !== exp_cnt || s_stall_pc !== 1'b1) begin
                errors++; $display("FAIL sat_cycle%0d cnt=%0d stall=%b exp %0d/1",
                                   i, s_stall_count, s_stall_pc, exp_cnt);
            end
        end
        halt = 1'b1;
        step(); settle();
        checks++;
        if (s_stall_pc !== 1'b0 || s_stall_count !== 4'd15) begin
            errors++; $display("FAIL sat_halt stall=%b cnt=%0d exp 0/15", s_stall_pc, s_stall_count);
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load();
        test_branch_alu();
        test_reg_zero();
        test_max_not_sum();
        test_reset_in_stall2();
        test_halt();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
